// File: rtl/serial_bus_pkg.sv
// Shared types and sizing helpers for the serial bus arbiter.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY
  } arb_state_t;

  localparam int unsigned MASTER_NO_DEF = 2;

  function automatic int unsigned msel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned MSEL_W_DEF = msel_w(MASTER_NO_DEF);

endpackage

// File: rtl/serial_bus_arbiter_picker.sv
// Round-robin picker: first requesting index after last_owner, wrapping modulo N.
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int unsigned N = MASTER_NO_DEF,
  parameter int unsigned W = msel_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = W'((32'(last_owner) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin bus arbiter with grant timeout and single-entry split parking.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int unsigned MASTER_NO     = MASTER_NO_DEF,
  parameter int unsigned GRANT_TIMEOUT = 4,
  localparam int unsigned MSEL_W       = msel_w(MASTER_NO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASTER_NO-1:0] bus_req,
  input  logic [MASTER_NO-1:0] bus_util,
  input  logic                 s_split,
  input  logic                 s_split_done,
  output logic [MASTER_NO-1:0] bus_grant,
  output logic [MASTER_NO-1:0] split_en,
  output logic [MSEL_W-1:0]    master_sel,
  output logic                 bus_busy
);

  localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [MASTER_NO-1:0] LSB_ONE = MASTER_NO'(1);

  arb_state_t               state_q, state_d;
  logic [MSEL_W-1:0]        last_owner_q, last_owner_d;
  logic [MSEL_W-1:0]        split_id_q, split_id_d;
  logic                     split_pending_q, split_pending_d;
  logic                     split_ready_q, split_ready_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MASTER_NO-1:0]     grant_d, split_en_d;
  logic [MSEL_W-1:0]        sel_d;
  logic                     busy_d;

  logic [MASTER_NO-1:0]     park_mask, eligible;
  logic                     pick_valid, resume;
  logic [MSEL_W-1:0]        pick_idx;

  // A parked master stays out of the normal search; once its slave is ready it is resumed first.
  assign park_mask = split_pending_q ? (LSB_ONE << split_id_q) : '0;
  assign eligible  = bus_req & ~park_mask;
  assign resume    = split_pending_q && split_ready_q && bus_req[split_id_q];

  rr_priority_picker #(
    .N (MASTER_NO),
    .W (MSEL_W)
  ) u_picker (
    .req        (eligible),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_comb begin
    state_d         = state_q;
    last_owner_d    = last_owner_q;
    split_id_d      = split_id_q;
    split_pending_d = split_pending_q;
    split_ready_d   = split_ready_q;
    cnt_d           = cnt_q;
    grant_d         = bus_grant;
    split_en_d      = '0;
    sel_d           = master_sel;
    busy_d          = bus_busy;

    if (s_split_done && split_pending_q) split_ready_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (resume || pick_valid) begin
          sel_d   = resume ? split_id_q : pick_idx;
          grant_d = LSB_ONE << (resume ? split_id_q : pick_idx);
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
          if (resume) begin
            split_pending_d = 1'b0;
            split_ready_d   = 1'b0;
          end
        end
      end
      ST_GRANT: begin
        if (bus_util[master_sel]) begin
          state_d = ST_BUSY;
        end else if (!bus_req[master_sel] || cnt_q == CNT_W'(GRANT_TIMEOUT)) begin
          grant_d      = '0;
          busy_d       = 1'b0;
          cnt_d        = '0;
          last_owner_d = master_sel;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (s_split && !split_pending_q) begin
          split_en_d      = bus_grant;
          split_id_d      = master_sel;
          split_pending_d = 1'b1;
          split_ready_d   = 1'b0;
          grant_d         = '0;
          busy_d          = 1'b0;
          cnt_d           = '0;
          last_owner_d    = master_sel;
          state_d         = ST_IDLE;
        end else if (!bus_util[master_sel]) begin
          grant_d      = '0;
          busy_d       = 1'b0;
          cnt_d        = '0;
          last_owner_d = master_sel;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_owner_q    <= MSEL_W'(MASTER_NO - 1);
      split_id_q      <= '0;
      split_pending_q <= 1'b0;
      split_ready_q   <= 1'b0;
      cnt_q           <= '0;
      bus_grant       <= '0;
      split_en        <= '0;
      master_sel      <= '0;
      bus_busy        <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_owner_q    <= last_owner_d;
      split_id_q      <= split_id_d;
      split_pending_q <= split_pending_d;
      split_ready_q   <= split_ready_d;
      cnt_q           <= cnt_d;
      bus_grant       <= grant_d;
      split_en        <= split_en_d;
      master_sel      <= sel_d;
      bus_busy        <= busy_d;
    end
  end

endmodule

// File: doc/serial_bus_arbiter.md
SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NO, default 2, number of bus masters (2..8).
REQ-002 SHALL have parameter GRANT_TIMEOUT, default 4, max cycles a granted master may take to assert bus_util.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bus_req  in  MASTER_NO  per-master bus request, level.
REQ-006 SHALL have port bus_util  in  MASTER_NO  per-master "bus in use" flag, level.
REQ-007 SHALL have port s_split  in  1  addressed slave requests a split of the current transfer.
REQ-008 SHALL have port s_split_done  in  1  split slave is ready to resume the parked master.
REQ-009 SHALL have port bus_grant  out  MASTER_NO  one-hot grant, or all zero.
REQ-010 SHALL have port split_en  out  MASTER_NO  one-cycle split notification to the owner.
REQ-011 SHALL have port master_sel  out  MSEL_W  index of the current owner for the bus mux; MSEL_W = max(1, clog2(MASTER_NO)).
REQ-012 SHALL have port bus_busy  out  1  high while any grant is active.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT and BUSY; all outputs registered.
REQ-014 In IDLE, on eligible request(s), SHALL select one owner and, on the same edge, assert its bus_grant bit, update master_sel, set bus_busy and enter GRANT; grant is visible one cycle after the request is sampled.
REQ-015 SHALL use round-robin selection: search starts at last_owner+1 modulo MASTER_NO.
REQ-016 A master parked by a split SHALL be ineligible until split_ready is set; once split_ready is set and that master requests, it SHALL win over all others.
REQ-017 In GRANT, SHALL count cycles from 1; bus_util[owner]=1 -> BUSY.
REQ-018 In GRANT, bus_req[owner]=0 or count = GRANT_TIMEOUT without bus_util SHALL clear the grant and return to IDLE, with last_owner = owner.
REQ-019 In BUSY, bus_grant SHALL be held; bus_util[owner] falling SHALL clear grant/bus_busy on the next edge, go IDLE and set last_owner = owner.
REQ-020 In BUSY, on s_split=1 with no split pending, SHALL:
  - pulse split_en[owner] for exactly one cycle;
  - record split_id = owner and set split_pending;
  - clear the grant and go IDLE.
REQ-021 On s_split while a split is already pending, SHALL not split: split_en stays 0 and the owner keeps the bus.
REQ-022 s_split in IDLE or GRANT SHALL be ignored.
REQ-023 s_split_done with split_pending SHALL set split_ready; with no pending split it SHALL be ignored.
REQ-024 Granting split_id with split_ready set SHALL clear split_pending and split_ready.
REQ-025 If s_split and s_split_done arrive in the same cycle with no pending split, the split SHALL be taken and split_ready left clear.
REQ-026 At most one bus_grant bit SHALL be high in any cycle; at least one IDLE cycle SHALL separate consecutive owners.
REQ-027 Request bits of non-owners SHALL not affect a grant in progress (no preemption).

Reset
REQ-028 On rst: bus_grant=0, split_en=0, master_sel=0, bus_busy=0, state IDLE.
REQ-029 On rst: last_owner=MASTER_NO-1 (master 0 wins first), split_pending=0, split_ready=0, counter=0.
REQ-030 rst asserted mid-transfer SHALL drop the grant immediately (asynchronous) and discard any pending split.

Structure
REQ-031 Shared package serial_bus_pkg SHALL hold the arbiter state enum, the MASTER_NO default and the MSEL_W function/constant.
REQ-032 Round-robin search SHALL be one combinational sub-module, rr_priority_picker (inputs: request vector, last_owner; outputs: valid, index).

Verification
REQ-033 Bench SHALL cover reset release with bus_req=2'b11 -> grant 2'b01 one cycle later; master 0 drops util -> IDLE, then grant 2'b10.
REQ-034 Bench SHALL cover grant to master 1 with bus_util held 0 for 4 cycles -> grant cleared at count 4; master 0 (requesting) granted next.
REQ-035 Bench SHALL cover split: master 0 in BUSY, s_split=1 -> split_en=2'b01 for one cycle, grant 0; master 0 request ignored while master 1 is served.
REQ-036 Bench SHALL cover s_split_done while master 1 is BUSY, then master 1 releases with both requesting -> master 0 granted first; split flags cleared.
REQ-037 Bench SHALL cover second s_split while a split is pending -> no split_en, owner keeps the bus.
REQ-038 Bench SHALL cover rst asserted during BUSY -> all outputs 0 the same cycle; after release, round-robin restarts at master 0.
